// File: rtl/heart_rate_calc.sv
// heart_rate_calc: converts peak spacing into averaged BPM with an N-deep IBI ring buffer and serial divider.
// Optional BEAT_LED_STRETCH_EN macro stretches beatLED to 100 ms after each accepted beat.
module heart_rate_calc #(
  parameter int TICK_DIV   = 40000,
  parameter int MIN_IBI_MS = 300,
  parameter int MAX_IBI_MS = 2000,
  parameter int AVG_LOG2   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       foundPeak,
  output logic [7:0] heartRate,
  output logic       rateValid,
  output logic       beatPulse,
  output logic       timeoutErr,
  output logic       beatLED
);

  // state   | meaning
  // IDLE    | waiting for the first peak, no interval running
  // MEASURE | timing the interval since the last accepted peak
  // DIVIDE  | serial 60000*N/sum division, one quotient bit per clk

  localparam int N    = 1 << AVG_LOG2;
  localparam int IBIW = 11;
  localparam int SUMW = IBIW + AVG_LOG2;
  localparam int NUMW = 16 + AVG_LOG2;
  localparam int PW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int FW   = AVG_LOG2 + 1;
  localparam int PRW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW   = $clog2(NUMW + 1);
  localparam logic [NUMW-1:0] NUMER = NUMW'(60000 << AVG_LOG2);
  localparam logic [FW-1:0]   FULL  = FW'(N);
  localparam logic [PW-1:0]   WLAST = PW'(N - 1);

  typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} state_t;
  state_t state, state_nx;

  logic            sync1, sync2, peak_q, pk_edge;
  logic [PRW-1:0]  presc;
  logic            tick;
  logic [IBIW-1:0] ibi;
  logic [IBIW-1:0] ring [N];
  logic [PW-1:0]   wptr;
  logic [FW-1:0]   fill, fill_nx;
  logic [SUMW-1:0] sum, sum_nx;
  logic [IBIW-1:0] evicted;
  logic [SUMW-1:0] divisor, rem;
  logic [NUMW-1:0] quo;
  logic [CW-1:0]   dcnt;
  logic [SUMW:0]   trial;
  logic            trial_ok;
  logic            in_range, accept, timeout, div_done;

  assign pk_edge  = sync2 & ~peak_q;
  assign tick     = (presc == PRW'(TICK_DIV - 1));
  assign in_range = (ibi >= IBIW'(MIN_IBI_MS)) && (ibi <= IBIW'(MAX_IBI_MS));
  assign evicted  = (fill == FULL) ? ring[wptr] : '0;
  assign fill_nx  = (fill == FULL) ? fill : fill + 1'b1;
  assign sum_nx   = sum + SUMW'(ibi) - SUMW'(evicted);
  assign trial    = {rem, quo[NUMW-1]};
  assign trial_ok = (trial >= {1'b0, divisor});

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // An accepted edge wins over a same-cycle timeout: the edge sees the pre-increment ibi.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    timeout  = 1'b0;
    div_done = 1'b0;
    case (state)
      IDLE: begin
        if (pk_edge) state_nx = MEASURE;
      end
      MEASURE: begin
        if (pk_edge && in_range) begin
          accept = 1'b1;
          if (fill_nx == FULL) state_nx = DIVIDE;
        end else if (tick && ibi == IBIW'(MAX_IBI_MS)) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end
      end
      DIVIDE: begin
        if (dcnt == CW'(NUMW)) begin
          div_done = 1'b1;
          state_nx = MEASURE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      peak_q     <= 1'b0;
      presc      <= '0;
      ibi        <= '0;
      wptr       <= '0;
      fill       <= '0;
      sum        <= '0;
      divisor    <= '0;
      rem        <= '0;
      quo        <= '0;
      dcnt       <= '0;
      heartRate  <= '0;
      rateValid  <= 1'b0;
      beatPulse  <= 1'b0;
      timeoutErr <= 1'b0;
      for (int i = 0; i < N; i++) ring[i] <= '0;
    end else begin
      sync1      <= foundPeak;
      sync2      <= sync1;
      peak_q     <= sync2;
      beatPulse  <= accept;
      timeoutErr <= timeout;

      if (state == IDLE || accept || timeout) begin
        presc <= '0;
        ibi   <= '0;
      end else if (tick) begin
        presc <= '0;
        ibi   <= ibi + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end

      if (accept) begin
        ring[wptr] <= ibi;
        wptr       <= (wptr == WLAST) ? '0 : wptr + 1'b1;
        fill       <= fill_nx;
        sum        <= sum_nx;
        if (fill_nx == FULL) begin
          divisor <= sum_nx;
          rem     <= '0;
          quo     <= NUMER;
          dcnt    <= '0;
        end
      end

      // Restoring step: the numerator shifts out of quo while quotient bits shift in.
      if (state == DIVIDE && !div_done) begin
        rem  <= trial_ok ? SUMW'(trial - {1'b0, divisor}) : trial[SUMW-1:0];
        quo  <= {quo[NUMW-2:0], trial_ok};
        dcnt <= dcnt + 1'b1;
      end

      if (div_done) begin
        heartRate <= (quo > NUMW'(255)) ? 8'hFF : quo[7:0];
        rateValid <= 1'b1;
      end

      if (timeout) begin
        wptr      <= '0;
        fill      <= '0;
        sum       <= '0;
        heartRate <= '0;
        rateValid <= 1'b0;
        for (int i = 0; i < N; i++) ring[i] <= '0;
      end
    end
  end

`ifdef BEAT_LED_STRETCH_EN
  localparam int LED_MS = 100;
  logic [6:0] led_cnt;

  always_ff @(posedge clk) begin
    if (reset || timeout)              led_cnt <= '0;
    else if (accept)                   led_cnt <= 7'(LED_MS);
    else if (tick && led_cnt != '0)    led_cnt <= led_cnt - 1'b1;
  end

  assign beatLED = (led_cnt != '0);
`else
  assign beatLED = beatPulse;
`endif

endmodule

// File: tb/tb_heart_rate_calc.sv
// tb_heart_rate_calc: scripted peak table plus random peaks, checked cycle-by-cycle against
// an interval-arithmetic model of heart_rate_calc (TICK_DIV=4).
module tb_heart_rate_calc;
  localparam int TD     = 4;
  localparam int MIN_MS = 300;
  localparam int MAX_MS = 2000;
  localparam int AL2    = 2;
  localparam int N      = 1 << AL2;
  localparam int NUMW   = 16 + AL2;

  logic       clk = 1'b0;
  logic       reset;
  logic       foundPeak;
  logic [7:0] heartRate;
  logic       rateValid, beatPulse, timeoutErr, beatLED;

  always #5 clk = ~clk;

  heart_rate_calc #(
    .TICK_DIV(TD), .MIN_IBI_MS(MIN_MS), .MAX_IBI_MS(MAX_MS), .AVG_LOG2(AL2)
  ) dut (
    .clk(clk), .reset(reset), .foundPeak(foundPeak), .heartRate(heartRate),
    .rateValid(rateValid), .beatPulse(beatPulse), .timeoutErr(timeoutErr), .beatLED(beatLED)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: mode 0 idle, 1 measuring, 2 dividing
  int m_mode, m_t0, m_hr, m_pend, m_done_at, m_led_until;
  bit m_valid;
  int m_q[$];
  bit e1, e2, e3;
  bit x_pulse, x_to, x_led, x_valid;
  int x_hr;

  int w_err, w_beats, w_mbeats, w_to, w_fc;
  logic [11:0] w_fa, w_fe;
  int rv_rise, to_cyc, last_drive, prev_drive;
  bit rv_prev;

  typedef struct {
    int gap_ms;
    int level;
    bit pre_rst;
    int rst_at;
    int beats;
    int tos;
    int hr;
    bit valid;
  } vec_t;
  vec_t vt[20];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic model_step(input bit fp, input bit rst);
    int k, ibi, s;
    bit edge_now;
    if (rst) begin
      m_mode = 0; m_q.delete(); m_hr = 0; m_valid = 0; m_led_until = -1;
      x_pulse = 0; x_to = 0; x_led = 0; x_valid = 0; x_hr = 0;
      e1 = 0; e2 = 0; e3 = 0;
      return;
    end
    edge_now = e2 & ~e3;
    k   = cyc - m_t0 - 1;
    ibi = k / TD;
    x_pulse = 0;
    x_to    = 0;
    case (m_mode)
      0: if (edge_now) begin
        m_mode = 1;
        m_t0   = cyc;
      end
      1: if (edge_now && ibi >= MIN_MS && ibi <= MAX_MS) begin
        x_pulse = 1;
        m_t0 = cyc;
        m_led_until = cyc + 100 * TD;
        m_q.push_back(ibi);
        if (m_q.size() > N) void'(m_q.pop_front());
        if (m_q.size() == N) begin
          s = 0;
          foreach (m_q[i]) s += m_q[i];
          m_pend = (60000 * N) / s;
          if (m_pend > 255) m_pend = 255;
          m_done_at = cyc + NUMW + 2;
          m_mode = 2;
        end
      end else if ((k % TD) == TD - 1 && ibi == MAX_MS) begin
        x_to = 1;
        m_mode = 0;
        m_q.delete();
        m_hr = 0;
        m_valid = 0;
        m_led_until = -1;
      end
      default: if (cyc + 1 == m_done_at) begin
        m_hr = m_pend;
        m_valid = 1;
        m_mode = 1;
      end
    endcase
    x_hr    = m_hr;
    x_valid = m_valid;
`ifdef BEAT_LED_STRETCH_EN
    x_led = (cyc + 1 <= m_led_until);
`else
    x_led = x_pulse;
`endif
    e3 = e2; e2 = e1; e1 = fp;
  endtask

  task automatic run_cycle(input bit fp, input bit rst);
    logic [11:0] act, expv;
    act  = {beatPulse, timeoutErr, beatLED, rateValid, heartRate};
    expv = {x_pulse, x_to, x_led, x_valid, 8'(x_hr)};
    if (act !== expv) begin
      w_err++;
      if (w_err == 1) begin w_fc = cyc; w_fa = act; w_fe = expv; end
    end
    w_beats  += int'(beatPulse);
    w_mbeats += int'(x_pulse);
    w_to     += int'(timeoutErr);
    if (rateValid && !rv_prev) rv_rise = cyc;
    rv_prev = rateValid;
    if (timeoutErr) to_cyc = cyc;
    foundPeak = fp;
    reset     = rst;
    model_step(fp, rst);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic close_window(input string tag);
    check($sformatf("%s_trace(first@%0d dut=%h model=%h)", tag, w_fc, w_fa, w_fe), w_err, 0);
    w_err = 0; w_beats = 0; w_mbeats = 0; w_to = 0;
    rv_rise = -1; to_cyc = -1;
  endtask

  task automatic do_peak(input int gap_ms, input int level, input bit pre_rst, input int rst_at);
    if (pre_rst) begin
      run_cycle(1'b0, 1'b1);
      run_cycle(1'b0, 1'b1);
    end
    while (cyc - last_drive < gap_ms * TD) run_cycle(1'b0, 1'b0);
    prev_drive = last_drive;
    last_drive = cyc;
    for (int j = 0; j < 60; j++) run_cycle(j < level, rst_at != 0 && j == rst_at);
  endtask

  initial begin
    // gap_ms, level, pre_rst, rst_at, beats, timeouts, hr, valid
    vt[0]  = '{5,    3,  0, 0, 0, 0, 0,  0};
    vt[1]  = '{1000, 3,  0, 0, 1, 0, 0,  0};
    vt[2]  = '{1000, 3,  0, 0, 1, 0, 0,  0};
    vt[3]  = '{1000, 3,  0, 0, 1, 0, 0,  0};
    vt[4]  = '{1000, 3,  0, 0, 1, 0, 60, 1};
    vt[5]  = '{1000, 3,  0, 0, 1, 0, 60, 1};
    vt[6]  = '{150,  3,  0, 0, 0, 0, 60, 1};
    vt[7]  = '{850,  3,  0, 0, 1, 0, 60, 1};
    vt[8]  = '{2100, 3,  0, 0, 0, 1, 0,  0};
    vt[9]  = '{1000, 3,  0, 0, 1, 0, 0,  0};
    vt[10] = '{1000, 3,  0, 0, 1, 0, 0,  0};
    vt[11] = '{500,  3,  0, 0, 1, 0, 0,  0};
    vt[12] = '{500,  3,  0, 0, 1, 0, 80, 1};
    vt[13] = '{500,  3,  0, 0, 1, 0, 96, 1};
    vt[14] = '{100,  50, 1, 0, 0, 0, 0,  0};
    vt[15] = '{1000, 50, 0, 0, 1, 0, 0,  0};
    vt[16] = '{1000, 50, 0, 0, 1, 0, 0,  0};
    vt[17] = '{1000, 50, 0, 0, 1, 0, 0,  0};
    vt[18] = '{1000, 50, 0, 0, 1, 0, 60, 1};
    vt[19] = '{1000, 50, 0, 8, 1, 0, 0,  0};

    m_mode = 0; m_t0 = 0; m_hr = 0; m_valid = 0; m_pend = 0; m_done_at = -1; m_led_until = -1;
    e1 = 0; e2 = 0; e3 = 0;
    x_pulse = 0; x_to = 0; x_led = 0; x_valid = 0; x_hr = 0;
    w_err = 0; w_beats = 0; w_mbeats = 0; w_to = 0; w_fc = -1; w_fa = '0; w_fe = '0;
    rv_rise = -1; to_cyc = -1; rv_prev = 0; last_drive = 0; prev_drive = 0;

    reset = 1'b1;
    foundPeak = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", int'({beatPulse, timeoutErr, beatLED, rateValid, heartRate}), 0);

    for (int i = 0; i < 20; i++) begin
      do_peak(vt[i].gap_ms, vt[i].level, vt[i].pre_rst, vt[i].rst_at);
      check($sformatf("v%0d_beats", i), w_beats, vt[i].beats);
      check($sformatf("v%0d_timeouts", i), w_to, vt[i].tos);
      check($sformatf("v%0d_heartRate", i), int'(heartRate), vt[i].hr);
      check($sformatf("v%0d_rateValid", i), int'(rateValid), int'(vt[i].valid));
      if (i == 4) check("valid_latency", rv_rise - (last_drive + 2), NUMW + 2);
      if (i == 8) check("timeout_cycle", to_cyc - (prev_drive + 2), (MAX_MS + 1) * TD + 1);
      close_window($sformatf("v%0d", i));
    end

    for (int r = 0; r < 6; r++) begin
      do_peak(int'($urandom_range(400, 120)), int'($urandom_range(60, 1)), 1'b0, 0);
      check($sformatf("rand%0d_beats", r), w_beats, w_mbeats);
      close_window($sformatf("rand%0d", r));
    end

    repeat (100) run_cycle(1'b0, 1'b0);
    close_window("tail");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
